// File: rtl/ila_capture_ctrl_pkg.sv
// Shared ILA definitions: capture controller state encoding and helpers.
package ila_capture_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_PREFILL   = 3'd1,
        S_WAIT_TRIG = 3'd2,
        S_POST      = 3'd3,
        S_DONE      = 3'd4
    } ila_state_t;

    function automatic logic state_is_busy(input ila_state_t s);
        return (s == S_PREFILL) || (s == S_WAIT_TRIG) || (s == S_POST);
    endfunction

endpackage

// File: rtl/ila_capture_ctrl.sv
// Write-side capture controller for the ILA ring buffer: pre-trigger window,
// trigger wait, post-trigger fill, then reports trigger and oldest-sample addresses.
module ila_capture_ctrl
    import ila_capture_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = 9
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  trig,
    input  logic [ADDR_WIDTH-1:0] pre_trig_len,
    output logic                  we,
    output logic [ADDR_WIDTH-1:0] addr_write,
    output logic                  busy,
    output logic                  armed,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] trig_addr,
    output logic [ADDR_WIDTH-1:0] first_addr
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = '1;

    ila_state_t            state_reg, state_next;
    logic                  we_reg, we_next;
    logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
    logic [ADDR_WIDTH-1:0] cnt_reg, cnt_next;
    logic [ADDR_WIDTH-1:0] pre_reg, pre_next;
    logic [ADDR_WIDTH-1:0] trig_addr_reg, trig_addr_next;
    logic [ADDR_WIDTH-1:0] first_addr_reg, first_addr_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= S_IDLE;
            we_reg         <= 1'b0;
            addr_reg       <= '0;
            cnt_reg        <= '0;
            pre_reg        <= '0;
            trig_addr_reg  <= '0;
            first_addr_reg <= '0;
        end else begin
            state_reg      <= state_next;
            we_reg         <= we_next;
            addr_reg       <= addr_next;
            cnt_reg        <= cnt_next;
            pre_reg        <= pre_next;
            trig_addr_reg  <= trig_addr_next;
            first_addr_reg <= first_addr_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        we_next         = 1'b0;
        addr_next       = addr_reg;
        cnt_next        = cnt_reg;
        pre_next        = pre_reg;
        trig_addr_next  = trig_addr_reg;
        first_addr_next = first_addr_reg;

        case (state_reg)
            S_IDLE, S_DONE: begin
                if (start) begin
                    // The port width already caps the window at DEPTH-1.
                    pre_next   = pre_trig_len;
                    addr_next  = '0;
                    cnt_next   = '0;
                    we_next    = 1'b1;
                    state_next = (pre_trig_len == '0) ? S_WAIT_TRIG : S_PREFILL;
                end
            end
            S_PREFILL: begin
                if (abort) begin
                    state_next = S_IDLE;
                end else begin
                    we_next   = 1'b1;
                    addr_next = addr_reg + ADDR_ONE;
                    cnt_next  = cnt_reg + ADDR_ONE;
                    if (cnt_reg + ADDR_ONE == pre_reg) begin
                        state_next = S_WAIT_TRIG;
                    end
                end
            end
            S_WAIT_TRIG: begin
                if (abort) begin
                    state_next = S_IDLE;
                end else if (trig) begin
                    trig_addr_next  = addr_reg;
                    first_addr_next = addr_reg - pre_reg;
                    // Post-trigger writes still owed after this trigger write.
                    cnt_next        = ADDR_MAX - pre_reg;
                    if (pre_reg == ADDR_MAX) begin
                        state_next = S_DONE;
                    end else begin
                        state_next = S_POST;
                        we_next    = 1'b1;
                        addr_next  = addr_reg + ADDR_ONE;
                    end
                end else begin
                    we_next   = 1'b1;
                    addr_next = addr_reg + ADDR_ONE;
                end
            end
            S_POST: begin
                if (abort) begin
                    state_next = S_IDLE;
                end else if (cnt_reg == ADDR_ONE) begin
                    state_next = S_DONE;
                end else begin
                    we_next   = 1'b1;
                    addr_next = addr_reg + ADDR_ONE;
                    cnt_next  = cnt_reg - ADDR_ONE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign we         = we_reg;
    assign addr_write = addr_reg;
    assign busy       = state_is_busy(state_reg);
    assign armed      = (state_reg == S_WAIT_TRIG);
    assign done       = (state_reg == S_DONE);
    assign trig_addr  = trig_addr_reg;
    assign first_addr = first_addr_reg;

endmodule

// File: tb/tb_ila_capture_ctrl.sv
// Bench for ila_capture_ctrl: directed capture table, hand-written corner
// sequences and random stimulus against a write-count based reference model.
module tb_ila_capture_ctrl;

    localparam int AW = 4;
    localparam int D  = 1 << AW;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          abort;
    logic          trig;
    logic [AW-1:0] pre_trig_len;
    logic          we;
    logic [AW-1:0] addr_write;
    logic          busy;
    logic          armed;
    logic          done;
    logic [AW-1:0] trig_addr;
    logic [AW-1:0] first_addr;

    int n_checks = 0;
    int n_errors = 0;

    ila_capture_ctrl #(.ADDR_WIDTH(AW)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .abort        (abort),
        .trig         (trig),
        .pre_trig_len (pre_trig_len),
        .we           (we),
        .addr_write   (addr_write),
        .busy         (busy),
        .armed        (armed),
        .done         (done),
        .trig_addr    (trig_addr),
        .first_addr   (first_addr)
    );

    always #5 clk = ~clk;

    // Reference model in terms of writes made since start and the index of
    // the trigger write; capture ends once DEPTH-pre writes follow the trigger.
    bit m_active;
    bit m_done;
    int m_n;
    int m_ti;
    int m_p;
    int m_taddr;
    int m_faddr;

    task automatic model_reset();
        m_active = 0; m_done = 0; m_n = 0; m_ti = -1; m_p = 0;
        m_taddr = 0; m_faddr = 0;
    endtask

    task automatic model_edge();
        if (m_active) begin
            if (abort) begin
                m_active = 0;
                m_done   = 0;
            end else begin
                if (m_ti < 0 && m_n >= m_p && trig) begin
                    m_ti    = m_n;
                    m_taddr = m_n % D;
                    m_faddr = (m_n - m_p) % D;
                end
                m_n++;
                if (m_ti >= 0 && m_n == m_ti + D - m_p) begin
                    m_active = 0;
                    m_done   = 1;
                end
            end
        end else if (start) begin
            m_active = 1; m_done = 0; m_n = 0; m_ti = -1;
            m_p = int'(pre_trig_len);
        end
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic check_model();
        chk("we",    int'(we),    int'(m_active));
        chk("busy",  int'(busy),  int'(m_active));
        chk("armed", int'(armed), int'(m_active && m_ti < 0 && m_n >= m_p));
        chk("done",  int'(done),  int'(m_done));
        if (m_active) chk("addr_write", int'(addr_write), m_n % D);
        if (m_done) begin
            chk("trig_addr",  int'(trig_addr),  m_taddr);
            chk("first_addr", int'(first_addr), m_faddr);
        end
    endtask

    task automatic step(input logic s, input logic a, input logic t, input logic [AW-1:0] p);
        start = s; abort = a; trig = t; pre_trig_len = p;
        @(posedge clk);
        model_edge();
        #1;
        check_model();
    endtask

    typedef struct {
        int pre;
        int hold;    // trig high on edges 0..hold after start
        int tcyc;    // additional single trigger edge
        int dcyc;    // expected cycle in which done first reads high
        int writes;
        int taddr;
        int faddr;
    } row_t;

    row_t rows [5];
    int   wr, dc;
    bit   tv;

    initial begin
        // pre=15 is the saturated value of an oversized request; a 4-bit port
        // cannot carry 20 itself.
        rows[0] = '{pre: 4,  hold: -1, tcyc: 10, dcyc: 22, writes: 21, taddr: 9,  faddr: 5};
        rows[1] = '{pre: 0,  hold: 1,  tcyc: 1,  dcyc: 17, writes: 16, taddr: 0,  faddr: 0};
        rows[2] = '{pre: 15, hold: 15, tcyc: 19, dcyc: 20, writes: 19, taddr: 2,  faddr: 3};
        rows[3] = '{pre: 8,  hold: -1, tcyc: 9,  dcyc: 17, writes: 16, taddr: 8,  faddr: 0};
        rows[4] = '{pre: 1,  hold: -1, tcyc: 30, dcyc: 45, writes: 44, taddr: 13, faddr: 12};

        rst = 1'b1; start = 0; abort = 0; trig = 0; pre_trig_len = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_we",         int'(we),         0);
        chk("rst_addr_write", int'(addr_write), 0);
        chk("rst_busy",       int'(busy),       0);
        chk("rst_armed",      int'(armed),      0);
        chk("rst_done",       int'(done),       0);
        chk("rst_trig_addr",  int'(trig_addr),  0);
        chk("rst_first_addr", int'(first_addr), 0);
        $display("reset: outputs checked");
        @(negedge clk);
        rst = 1'b0;

        // Directed capture table
        for (int r = 0; r < 5; r++) begin
            wr = 0; dc = -1;
            for (int e = 0; e < 70 && dc < 0; e++) begin
                tv = (e <= rows[r].hold) || (e == rows[r].tcyc);
                step(e == 0, 1'b0, tv, AW'(rows[r].pre));
                if (we) wr++;
                if (done) dc = e + 1;
            end
            chk("row_done_cycle", dc,               rows[r].dcyc);
            chk("row_writes",     wr,               rows[r].writes);
            chk("row_trig_addr",  int'(trig_addr),  rows[r].taddr);
            chk("row_first_addr", int'(first_addr), rows[r].faddr);
            $display("capture pre=%0d: done cycle %0d, writes %0d, trig_addr %0d, first_addr %0d",
                     rows[r].pre, dc, wr, trig_addr, first_addr);
        end

        // Abort during POST, with an ignored start while busy and start+abort together
        step(1, 0, 0, 4'd2);
        for (int e = 1; e < 5; e++) step(0, 0, 0, 4'd2);
        step(0, 0, 1, 4'd2);
        step(1, 0, 0, 4'd2);
        step(0, 0, 0, 4'd2);
        step(1, 1, 0, 4'd2);
        chk("abort_we",         int'(we),         0);
        chk("abort_busy",       int'(busy),       0);
        chk("abort_done",       int'(done),       0);
        chk("abort_trig_addr",  int'(trig_addr),  4);
        chk("abort_first_addr", int'(first_addr), 2);
        step(1, 0, 0, 4'd5);
        chk("restart_we",   int'(we),         1);
        chk("restart_addr", int'(addr_write), 0);
        $display("abort in POST: idle next cycle, restart from addr %0d", addr_write);
        for (int e = 0; e < 40 && !done; e++) step(0, 0, (e % 7) == 6, 4'd5);
        chk("restart_completes", int'(done), 1);

        // Asynchronous reset in the middle of WAIT_TRIG
        step(1, 0, 0, 4'd3);
        for (int e = 1; e < 6; e++) step(0, 0, 0, 4'd3);
        chk("pre_async_armed", int'(armed), 1);
        #2 rst = 1'b1;
        #1;
        chk("async_we",    int'(we),    0);
        chk("async_busy",  int'(busy),  0);
        chk("async_armed", int'(armed), 0);
        chk("async_done",  int'(done),  0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        $display("async reset in WAIT_TRIG: outputs dropped before the next edge");

        // Random stimulus against the model
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 7) == 0,
                 $urandom_range(0, 40) == 0,
                 $urandom_range(0, 5) == 0,
                 AW'($urandom_range(0, D - 1)));
        end
        $display("random: 3000 cycles compared against the reference model");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ila_capture_ctrl.md
# ila_capture_ctrl

Write-side capture controller for the ILA sample buffer. It drives the buffer's write enable and write address as a circular ring. It holds a programmable pre-trigger window, waits for the trigger, then fills the remaining depth with post-trigger samples. On completion it reports the trigger address and the oldest-sample address so the readout path can start unloading. It runs entirely in the sampling clock domain, directly upstream of the single-port buffer's write port.

## Interface
- ADDR_WIDTH, 9, buffer address width; DEPTH = 2**ADDR_WIDTH samples
- clk  in  1  sampling clock (same clock as the buffer write port)
- rst  in  1  asynchronous, active-high reset
- start  in  1  arm request; sampled only in IDLE or DONE
- abort  in  1  cancel capture; sampled in PREFILL, WAIT_TRIG, POST
- trig  in  1  trigger condition, aligned with the sample presented to the buffer this cycle
- pre_trig_len  in  ADDR_WIDTH  pre-trigger sample count; latched on accepted start
- we  out  1  buffer write enable (registered)
- addr_write  out  ADDR_WIDTH  buffer write address (registered)
- busy  out  1  high in PREFILL, WAIT_TRIG, POST
- armed  out  1  high in WAIT_TRIG only
- done  out  1  high in DONE only
- trig_addr  out  ADDR_WIDTH  address of the trigger sample, valid while done
- first_addr  out  ADDR_WIDTH  oldest valid sample = trig_addr − pre (mod DEPTH), valid while done

## Operation
- States: IDLE, PREFILL, WAIT_TRIG, POST, DONE. Reset enters IDLE.
- Reset values: all outputs 0.
- Latched pre is min(pre_trig_len, DEPTH−1).
- IDLE/DONE + start:
  - addr_write ← 0 and counter ← 0.
  - Next state is PREFILL, or WAIT_TRIG if pre = 0.
  - Entering from DONE clears done.
- PREFILL:
  - we=1; addr_write increments each cycle, wrapping modulo DEPTH.
  - trig is ignored.
  - After pre writes, go to WAIT_TRIG.
- WAIT_TRIG:
  - we=1; addr_write keeps incrementing and overwrites the ring.
  - On trig=1: the current addr_write becomes trig_addr, post counter ← DEPTH−pre−1, next state POST. If that count is 0, next state is DONE.
- POST:
  - we=1; one write per cycle.
  - After the final write, go to DONE.
  - Total writes from the trigger write through the last POST write = DEPTH−pre.
- DONE:
  - we=0, done=1.
  - trig_addr and first_addr are held until the next accepted start.
- abort in a busy state: go to IDLE next cycle, with we=0 and done=0. trig_addr and first_addr are unchanged.
- start while busy is ignored. Simultaneous start and abort while busy: abort wins.
- Asynchronous rst at any point: IDLE immediately, all outputs 0.
- All address arithmetic is ADDR_WIDTH bits and wraps naturally; there are no overflow flags.

## Timing
- start sampled high at edge k: we=1 and addr_write=0 from cycle k+1.
- Address sequence: one new address per cycle while we=1; there are no gaps.
- trig sampled at edge t in WAIT_TRIG: the write at addr_write(t) is the trigger sample; POST begins at cycle t+1.
- done rises in the cycle after the last write; we falls in the same cycle.
- Any sample delay inside the buffer lies on the data path only; this block does no compensation.

## Structure
- Shared ILA package: state enum and its encoding.
- Single module; no sub-module needed. The ring address counter and the window counter are inline registers.

## Test plan
- ADDR_WIDTH=4, pre=4, start at cycle 0, trig at cycle 10:
  - PREFILL writes addresses 0–3 in cycles 1–4.
  - The trigger write goes to address 9; trig_addr=9.
  - POST writes 11 samples to addresses 10–15, then 0–4.
  - done=1 and we=0 at cycle 22; first_addr=5.
- pre=0 with trig held high through the start:
  - WAIT_TRIG is entered directly; trig_addr=0 and first_addr=0.
  - 16 writes total, done at cycle 17.
- pre=20 (saturates to 15):
  - trig held high during PREFILL is ignored.
  - Trigger at address 2 gives DONE the next cycle, trig_addr=2, first_addr=3.
- abort during POST: IDLE next cycle with we=0 and done=0. A following start restarts cleanly from addr 0.
- rst asserted asynchronously mid-WAIT_TRIG: we, busy and armed drop immediately, without waiting for a clock edge.
- start pulses while busy: ignored. start in DONE: done clears, addr restarts at 0.
